rgb_led_arbiter: RTL

Shares the board's single active-low RGB LED among `NREQ` requesters. Each requester asks to show one 24-bit colour. The block grants requests round-robin and drives the colour through per-channel PWM for a fixed hold time, then signals completion. It sits between application logic (status, heartbeat, error indicators) and the `LED_R`/`LED_G`/`LED_B` pins, replacing direct counter-driven LED outputs.

---
 rtl/led_pkg.sv | 32 +++
 rtl/rgb_pwm.sv | 50 +++++
 rtl/rgb_led_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants, state encoding and colour-slot extraction for the
// round-robin RGB LED arbiter.
package led_pkg;

  localparam int RGB_W    = 24;
  localparam int R_OFF    = 16;
  localparam int G_OFF    = 8;
  localparam int B_OFF    = 0;
  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  // Constant-base select per slot keeps the mux free of a wide variable shifter.
  function automatic logic [RGB_W-1:0] rgb_slot(
    input logic [MAX_NREQ*RGB_W-1:0] bus,
    input int                        idx
  );
    logic [RGB_W-1:0] slot;
    slot = '0;
    for (int s = 0; s < MAX_NREQ; s++) begin
      if (idx == s) begin
        slot = bus[s*RGB_W +: RGB_W];
      end
    end
    return slot;
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM sharing one free-running counter; drives are registered
// and active-low, forced off whenever the display is not enabled.
module rgb_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [RGB_W-1:0] colour,
  output logic             led_r_n,
  output logic             led_g_n,
  output logic             led_b_n
);

  logic [PWM_BITS-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    localparam int OFF = (gi == 0) ? R_OFF : ((gi == 1) ? G_OFF : B_OFF);

    logic [PWM_BITS-1:0] w_duty;
    logic                r_led_n;

    assign w_duty = colour[OFF +: PWM_BITS];

    // Lit while the counter is below duty, so duty 0 never lights.
    always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
        r_led_n <= 1'b1;
      end else begin
        r_led_n <= ~(r_cnt < w_duty);
      end
    end
  end

  assign led_r_n = g_ch[0].r_led_n;
  assign led_g_n = g_ch[1].r_led_n;
  assign led_b_n = g_ch[2].r_led_n;

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the shared active-low RGB LED: grants one requester at
// a time, shows its colour through PWM for HOLD_CYCLES, then reports done.
module rgb_led_arbiter
  import led_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int PWM_BITS    = 8,
  parameter int HOLD_CYCLES = 12_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*RGB_W-1:0] rgb,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  LED_R,
  output logic                  LED_G,
  output logic                  LED_B
);

  localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NREQ - 1);

  led_state_t       r_state, w_state_next;
  logic [IW-1:0]    r_ptr, w_ptr_next;
  logic [IW-1:0]    r_owner, w_owner_next;
  logic [HW-1:0]    r_hold, w_hold_next;
  logic [RGB_W-1:0] r_colour, w_colour_next;
  logic [NREQ-1:0]  r_grant, w_grant_next;
  logic [NREQ-1:0]  r_done, w_done_next;
  logic             r_busy, w_busy_next;

  logic                      w_hit;
  logic [IW-1:0]             w_win;
  int                        w_best;
  logic [MAX_NREQ*RGB_W-1:0] w_rgb_pad;
  logic                      w_pwm_clr;
  logic                      w_pwm_en;

  always_comb begin
    w_rgb_pad                   = '0;
    w_rgb_pad[NREQ*RGB_W-1:0]   = rgb;
  end

  // Winner is the requester with the smallest rotational distance from ptr.
  always_comb begin
    w_hit  = 1'b0;
    w_win  = '0;
    w_best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (((i - int'(r_ptr)) + NREQ) % NREQ) < w_best) begin
        w_hit  = 1'b1;
        w_win  = IW'(i);
        w_best = ((i - int'(r_ptr)) + NREQ) % NREQ;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_owner_next  = r_owner;
    w_hold_next   = r_hold;
    w_colour_next = r_colour;
    w_grant_next  = '0;
    w_done_next   = '0;
    w_busy_next   = r_busy;
    w_pwm_clr     = 1'b0;
    w_pwm_en      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (w_hit) begin
          w_state_next  = SHOW;
          w_owner_next  = w_win;
          w_colour_next = rgb_slot(w_rgb_pad, int'(w_win));
          w_grant_next  = NREQ'(1) << w_win;
          w_ptr_next    = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
          w_hold_next   = '0;
          w_busy_next   = 1'b1;
          w_pwm_clr     = 1'b1;
        end
      end

      SHOW: begin
        w_busy_next = 1'b1;
        if (r_hold == HOLD_LAST) begin
          w_state_next = GAP;
          w_done_next  = NREQ'(1) << r_owner;
          w_hold_next  = '0;
        end else begin
          // Drives keep PWM only while the next cycle is still SHOW.
          w_hold_next = r_hold + 1'b1;
          w_pwm_en    = 1'b1;
        end
      end

      GAP: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_hold   <= '0;
      r_colour <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_owner  <= w_owner_next;
      r_hold   <= w_hold_next;
      r_colour <= w_colour_next;
      r_grant  <= w_grant_next;
      r_done   <= w_done_next;
      r_busy   <= w_busy_next;
    end
  end

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_pwm_clr),
    .en     (w_pwm_en),
    .colour (r_colour),
    .led_r_n(LED_R),
    .led_g_n(LED_G),
    .led_b_n(LED_B)
  );

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule
